// File: rtl/lane_arb_pkg.sv
// Shared types and constants for the lane arbiter: state encoding, the
// "no owner" index and default sizing.
package lane_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GAP   = 2'd1,
        GRANT = 2'd2
    } arb_state_e;

    localparam logic [2:0] IDX_NONE  = 3'd7;
    localparam int         N_LANES_DEF = 5;
    localparam int         CNT_W_DEF   = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of (req & mask) searching
// upward from last_owner+1, wrapping; index is IDX_NONE when nothing qualifies.
module rr_pick
    import lane_arb_pkg::*;
#(
    parameter int N_LANES = N_LANES_DEF
) (
    input  logic [N_LANES-1:0] req,
    input  logic [N_LANES-1:0] mask,
    input  logic [2:0]         last_owner,
    output logic [N_LANES-1:0] onehot,
    output logic [2:0]         idx
);

    logic [N_LANES-1:0] cand_s;
    logic               found_s;

    // Two passes: lanes above the last owner first, then wrap to the bottom.
    always_comb begin
        cand_s  = req & mask;
        onehot  = {N_LANES{1'b0}};
        idx     = IDX_NONE;
        found_s = 1'b0;
        for (int j = 0; j < N_LANES; j++) begin
            if (!found_s && cand_s[j] && (j > int'(last_owner))) begin
                found_s   = 1'b1;
                onehot[j] = 1'b1;
                idx       = 3'(j);
            end else begin
                found_s = found_s;
            end
        end
        for (int j = 0; j < N_LANES; j++) begin
            if (!found_s && cand_s[j]) begin
                found_s   = 1'b1;
                onehot[j] = 1'b1;
                idx       = 3'(j);
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/lane_arbiter.sv
// Round-robin burst arbiter with a one-cycle break-before-make gap between
// grants. Optional strict priority class enabled by LANE_ARB_PRIORITY_EN.
module lane_arbiter
    import lane_arb_pkg::*;
#(
    parameter int N_LANES = N_LANES_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_LANES-1:0] req,
    input  logic [CNT_W-1:0]   burst_len,
    input  logic               done,
`ifdef LANE_ARB_PRIORITY_EN
    input  logic [N_LANES-1:0] prio,
`endif
    output logic [N_LANES-1:0] sel,
    output logic [2:0]         sel_idx,
    output logic               busy,
    output logic               grant_start
);

    arb_state_e         state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [2:0]         last_owner_r;
    logic [N_LANES-1:0] mask_s;
    logic [N_LANES-1:0] pick_onehot_s;
    logic [2:0]         pick_idx_s;
    logic               any_req_s;
    logic               owner_req_s;
    logic               grant_end_s;

    // Priority lanes, when any are requesting, hide all other lanes from the picker.
    always_comb begin
`ifdef LANE_ARB_PRIORITY_EN
        if ((req & prio) != {N_LANES{1'b0}}) begin
            mask_s = prio;
        end else begin
            mask_s = {N_LANES{1'b1}};
        end
`else
        mask_s = {N_LANES{1'b1}};
`endif
    end

    rr_pick #(.N_LANES(N_LANES)) u_rr_pick (
        .req        (req),
        .mask       (mask_s),
        .last_owner (last_owner_r),
        .onehot     (pick_onehot_s),
        .idx        (pick_idx_s)
    );

    // Grant termination: counter expiry, early done, or owner withdrawing.
    always_comb begin
        any_req_s   = (req != {N_LANES{1'b0}});
        owner_req_s = ((req & sel) != {N_LANES{1'b0}});
        grant_end_s = (cnt_r == {CNT_W{1'b0}}) || done || !owner_req_s;
    end

    // Arbitration FSM with registered grant outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            last_owner_r <= 3'(N_LANES - 1);
            sel          <= {N_LANES{1'b0}};
            sel_idx      <= IDX_NONE;
            busy         <= 1'b0;
            grant_start  <= 1'b0;
        end else begin
            case (state_r)
                IDLE, GAP: begin
                    if (any_req_s) begin
                        state_r      <= GRANT;
                        cnt_r        <= burst_len;
                        last_owner_r <= pick_idx_s;
                        sel          <= pick_onehot_s;
                        sel_idx      <= pick_idx_s;
                        busy         <= 1'b1;
                        grant_start  <= 1'b1;
                    end else begin
                        state_r     <= IDLE;
                        sel         <= {N_LANES{1'b0}};
                        sel_idx     <= IDX_NONE;
                        busy        <= 1'b0;
                        grant_start <= 1'b0;
                    end
                end
                GRANT: begin
                    grant_start <= 1'b0;
                    if (grant_end_s) begin
                        state_r <= GAP;
                        cnt_r   <= {CNT_W{1'b0}};
                        sel     <= {N_LANES{1'b0}};
                        sel_idx <= IDX_NONE;
                        busy    <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= {CNT_W{1'b0}};
                    sel         <= {N_LANES{1'b0}};
                    sel_idx     <= IDX_NONE;
                    busy        <= 1'b0;
                    grant_start <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lane_arbiter.sv
// Directed self-checking bench for lane_arbiter (covers LANE_ARB_PRIORITY_EN
// when that macro is defined).
module tb_lane_arbiter;

    logic       clk;
    logic       rst;
    logic [4:0] req;
    logic [3:0] burst_len;
    logic       done;
`ifdef LANE_ARB_PRIORITY_EN
    logic [4:0] prio;
`endif
    logic [4:0] sel;
    logic [2:0] sel_idx;
    logic       busy;
    logic       grant_start;

    int errors = 0;
    int checks = 0;

    lane_arbiter #(.N_LANES(5), .CNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .burst_len   (burst_len),
        .done        (done),
`ifdef LANE_ARB_PRIORITY_EN
        .prio        (prio),
`endif
        .sel         (sel),
        .sel_idx     (sel_idx),
        .busy        (busy),
        .grant_start (grant_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge; outputs are then stable and inputs may change.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check the owner index and that sel matches it (zero when no owner).
    task automatic check_owner(input string tag, input logic [2:0] exp_idx);
        logic [4:0] exp_sel;
        exp_sel = (exp_idx == 3'd7) ? 5'd0 : (5'd1 << exp_idx);
        check({tag, "_idx"}, 32'(sel_idx), 32'(exp_idx));
        check({tag, "_sel"}, 32'(sel), 32'(exp_sel));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 5'd0;
        done = 1'b0;
        step();
        rst = 1'b0;
    endtask

    logic [2:0] seq_rr [11];

    initial begin
        rst = 1'b1;
        req = 5'd0;
        burst_len = 4'd0;
        done = 1'b0;
`ifdef LANE_ARB_PRIORITY_EN
        prio = 5'd0;
`endif
        seq_rr = '{3'd0, 3'd7, 3'd1, 3'd7, 3'd2, 3'd7, 3'd3, 3'd7, 3'd4, 3'd7, 3'd0};

        // Reset state
        step();
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_idx", 32'(sel_idx), 32'd7);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gs", 32'(grant_start), 32'd0);

        // Sole requester, 3-cycle bursts with one-cycle hole, then withdrawal
        rst = 1'b0;
        req = 5'b00001;
        burst_len = 4'd2;
        step();
        check_owner("solo_g1", 3'd0);
        check("solo_g1_gs", 32'(grant_start), 32'd1);
        check("solo_g1_busy", 32'(busy), 32'd1);
        step();
        check_owner("solo_g2", 3'd0);
        check("solo_g2_gs", 32'(grant_start), 32'd0);
        step();
        check_owner("solo_g3", 3'd0);
        step();
        check_owner("solo_gap", 3'd7);
        check("solo_gap_busy", 32'(busy), 32'd0);
        step();
        check_owner("solo_regrant", 3'd0);
        check("solo_regrant_gs", 32'(grant_start), 32'd1);
        req = 5'd0;
        step();
        check_owner("drop_gap", 3'd7);
        step();
        check_owner("drop_idle", 3'd7);
        check("drop_idle_busy", 32'(busy), 32'd0);

        // All lanes requesting, single-cycle bursts rotate through every lane
        do_reset();
        req = 5'b11111;
        burst_len = 4'd0;
        for (int i = 0; i < 11; i++) begin
            step();
            check_owner($sformatf("rr%0d", i), seq_rr[i]);
        end
        req = 5'd0;
        step();
        step();

        // Early done on the 3rd cycle; burst_len change mid-grant ignored
        do_reset();
        req = 5'b01100;
        burst_len = 4'd7;
        step();
        check_owner("done_g1", 3'd2);
        burst_len = 4'd0;
        step();
        check_owner("done_g2", 3'd2);
        step();
        check_owner("done_g3", 3'd2);
        done = 1'b1;
        step();
        done = 1'b0;
        check_owner("done_gap", 3'd7);
        step();
        check_owner("done_next", 3'd3);
        req = 5'd0;
        step();
        step();

        // Reset during the 2nd grant cycle
        do_reset();
        req = 5'b10100;
        burst_len = 4'd3;
        step();
        check_owner("mrst_g1", 3'd2);
        step();
        check_owner("mrst_g2", 3'd2);
        rst = 1'b1;
        step();
        check_owner("mrst_after", 3'd7);
        check("mrst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step();
        check_owner("mrst_regrant", 3'd2);
        check("mrst_regrant_gs", 32'(grant_start), 32'd1);
        req = 5'd0;
        step();
        step();

`ifdef LANE_ARB_PRIORITY_EN
        // Priority lane 1 repeatedly beats lane 0
        do_reset();
        req = 5'b00011;
        prio = 5'b00010;
        burst_len = 4'd0;
        for (int i = 0; i < 6; i++) begin
            step();
            check_owner($sformatf("prio%0d", i), (i % 2 == 0) ? 3'd1 : 3'd7);
        end
`else
        // Two lanes alternate under pure round-robin
        do_reset();
        req = 5'b00011;
        burst_len = 4'd0;
        for (int i = 0; i < 6; i++) begin
            step();
            check_owner($sformatf("alt%0d", i),
                        (i % 2 == 1) ? 3'd7 : ((i % 4 == 0) ? 3'd0 : 3'd1));
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
